bht_btb_predictor: RTL and testbench
====================================

Name: bht_btb_predictor

Overview:
- Dynamic branch predictor in the IF stage.
- Direct-mapped BTB with a 2-bit saturating counter per entry.
- Each cycle it supplies a taken/target prediction for the fetch PC.
- It is trained by resolved branches from EX and produces the EX mispredict/redirect signal consumed by the hazard unit as the branch-predicted input.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- IDX_BITS, 6: index width; table holds 2**IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
- CNT_INIT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- pc_IF  input  32  current fetch PC
- pred_taken_IF  output  1  predict taken for pc_IF
- pred_target_IF  output  32  predicted target; 0 when pred_taken_IF=0
- upd_valid_EX  input  1  a conditional branch/jump resolved in EX this cycle
- upd_pc_EX  input  32  PC of the resolved instruction
- upd_taken_EX  input  1  actual direction
- upd_target_EX  input  32  actual target
- pred_taken_EX  input  1  prediction carried down the pipeline with this instruction
- pred_target_EX  input  32  predicted target carried down the pipeline
- mispredict_EX  output  1  redirect required (to hazard unit: flush IF/ID and ID/EX)
- redirect_pc_EX  output  32  correct next PC on mispredict
- init_busy  output  1  table clear in progress
- stat_branches  output  32  resolved-branch count
- stat_mispredicts  output  32  mispredict count

Behaviour:
- Entry fields: valid, tag = pc[31:IDX_BITS+2], target[31:0], cnt[1:0].
- FSM states:
  - INIT: clears one entry per cycle via an index counter 0..2**IDX_BITS-1. Entry clear = valid=0, cnt=0. Moves to RUN after the last entry, i.e. 2**IDX_BITS cycles after rst deasserts.
  - RUN: normal operation.
  - rst in any state → INIT with index 0 (reset mid-init restarts the clear).
- init_busy = 1 in INIT, 0 in RUN.
- Reset values:
  - init_busy=1.
  - stat_branches = 0, stat_mispredicts = 0.
  - pred_taken_IF = 0, pred_target_IF = 0.
- Lookup (combinational, zero latency):
  - hit = RUN && valid && tag match.
  - pred_taken_IF = hit && cnt[1].
  - pred_target_IF = entry.target when pred_taken_IF, else 0.
- Mispredict (combinational):
  - mispredict_EX = upd_valid_EX && (pred_taken_EX != upd_taken_EX || (upd_taken_EX && pred_target_EX != upd_target_EX)).
  - redirect_pc_EX = upd_taken_EX ? upd_target_EX : upd_pc_EX + 4. Computed regardless of upd_valid_EX.
  - Both are valid in INIT as well, so the pipeline always recovers.
- Training (clocked, RUN only, on upd_valid_EX; updates during INIT are dropped):
  - Tag hit:
    - cnt saturating +1 if taken (max 3), -1 if not taken (min 0).
    - target overwritten with upd_target_EX when taken.
    - valid stays 1 even when cnt reaches 0.
  - Tag miss and taken: allocate (overwrite): valid=1, tag, target=upd_target_EX, cnt=CNT_INIT.
  - Tag miss and not taken: no write.
- Simultaneous lookup and update of the same index: lookup returns the pre-update entry; the new value is visible the next cycle.
- Statistics:
  - In any state, stat_branches +1 per upd_valid_EX.
  - stat_mispredicts +1 per mispredict_EX.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
- pc_IF bits [1:0] ignored.

Test Plan:
- rst for 1 cycle then release → init_busy=1 for exactly 64 cycles; pred_taken_IF=0 for every pc_IF; then init_busy=0. Reassert rst at cycle 30 → a full 64-cycle clear restarts.
- After init, update pc=0x100, taken, target=0x80, pred_taken_EX=0 → mispredict_EX=1, redirect_pc_EX=0x80. Next cycle pc_IF=0x100 → pred_taken_IF=1, target=0x80 (cnt=2).
- Same branch not taken twice → cnt 2→1→0. pc_IF=0x100 → pred_taken_IF=0. Update taken twice → predicts taken again.
- Aliasing: train 0x100 taken, then update pc=0x200 (same index, different tag) taken target 0x40 → entry replaced; pc_IF=0x100 misses (pred 0); pc_IF=0x200 predicts 0x40.
- Target change: pred_taken_EX=1, pred_target_EX=0x80, actual taken target 0x90 → mispredict_EX=1, redirect 0x90; entry target becomes 0x90. Not-taken resolution of pc=0x300 with pred_taken_EX=1 → redirect_pc_EX=0x304.
- Same-cycle pc_IF=0x100 lookup and update of 0x100 → pre-update prediction that cycle, updated prediction next cycle. Force stat counters near max → saturate at 0xFFFFFFFF.

Source files
------------

// File: rtl/bht_btb_predictor_if.sv
// ----------------------------------------------------------------------------
// bht_btb_predictor_if
// Purpose : Groups the fetch-lookup, EX-training/redirect and status signals of
//           the BHT/BTB branch predictor into a single bundle.
// Signals :
//   pc_IF            fetch PC (master -> predictor)
//   pred_taken_IF    predict-taken for pc_IF (predictor -> master)
//   pred_target_IF   predicted target, 0 when not predicted taken
//   upd_valid_EX     resolved branch/jump present in EX
//   upd_pc_EX        PC of the resolved instruction
//   upd_taken_EX     actual direction
//   upd_target_EX    actual target
//   pred_taken_EX    prediction carried down the pipe with the instruction
//   pred_target_EX   predicted target carried down the pipe
//   mispredict_EX    redirect required
//   redirect_pc_EX   correct next PC
//   init_busy        table clear in progress
//   stat_branches    saturating resolved-branch count
//   stat_mispredicts saturating mispredict count
// ----------------------------------------------------------------------------
interface bht_btb_predictor_if;
    logic [31:0] pc_IF;
    logic        pred_taken_IF;
    logic [31:0] pred_target_IF;
    logic        upd_valid_EX;
    logic [31:0] upd_pc_EX;
    logic        upd_taken_EX;
    logic [31:0] upd_target_EX;
    logic        pred_taken_EX;
    logic [31:0] pred_target_EX;
    logic        mispredict_EX;
    logic [31:0] redirect_pc_EX;
    logic        init_busy;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output pc_IF, upd_valid_EX, upd_pc_EX, upd_taken_EX, upd_target_EX,
        output pred_taken_EX, pred_target_EX,
        input  pred_taken_IF, pred_target_IF, mispredict_EX, redirect_pc_EX,
        input  init_busy, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pc_IF, upd_valid_EX, upd_pc_EX, upd_taken_EX, upd_target_EX,
        input  pred_taken_EX, pred_target_EX,
        output pred_taken_IF, pred_target_IF, mispredict_EX, redirect_pc_EX,
        output init_busy, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/bht_btb_predictor.sv
// ----------------------------------------------------------------------------
// bht_btb_predictor
// Purpose : Direct-mapped BTB with a 2-bit saturating direction counter per
//           entry. Supplies a zero-latency taken/target prediction for the
//           fetch PC, is trained by branches resolved in EX, flags EX
//           mispredicts with the correct redirect PC and keeps saturating
//           branch/mispredict statistics. After reset the table is cleared one
//           entry per cycle (init_busy high) before predictions are enabled.
// Ports   :
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (restarts the table clear)
//   bus  - bht_btb_predictor_if.slave: fetch lookup, EX training/redirect,
//          init_busy and statistics
// ----------------------------------------------------------------------------
module bht_btb_predictor #(
    parameter int unsigned IDX_BITS = 6,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic               clk,
    input  logic               rst,
    bht_btb_predictor_if.slave bus
);
    localparam int unsigned ENTRIES  = 1 << IDX_BITS;
    localparam int unsigned TAG_BITS = 30 - IDX_BITS;

    typedef enum logic {StInit, StRun} state_e;

    state_e              r_state, w_state_next;
    logic [IDX_BITS-1:0] r_init_idx, w_init_idx_next;
    logic [31:0]         r_stat_branches, r_stat_mispredicts;
    logic [31:0]         w_stat_branches_next, w_stat_mispredicts_next;

    // Table storage; contents are cleared by the INIT walk, not by rst.
    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_cnt    [ENTRIES];

    // Fetch-side lookup.
    logic [IDX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic                w_lk_hit;
    logic                w_unused_pc_bits;

    assign w_lk_idx         = bus.pc_IF[IDX_BITS+1:2];
    assign w_lk_tag         = bus.pc_IF[31:IDX_BITS+2];
    assign w_unused_pc_bits = ^bus.pc_IF[1:0];
    assign w_lk_hit         = (r_state == StRun) && r_valid[w_lk_idx]
                              && (r_tag[w_lk_idx] == w_lk_tag);

    assign bus.pred_taken_IF  = w_lk_hit && r_cnt[w_lk_idx][1];
    assign bus.pred_target_IF = bus.pred_taken_IF ? r_target[w_lk_idx] : 32'd0;

    // EX resolution; valid in every state so the pipeline always recovers.
    assign bus.mispredict_EX  = bus.upd_valid_EX
                                && ((bus.pred_taken_EX != bus.upd_taken_EX)
                                    || (bus.upd_taken_EX
                                        && (bus.pred_target_EX != bus.upd_target_EX)));
    assign bus.redirect_pc_EX = bus.upd_taken_EX ? bus.upd_target_EX
                                                 : bus.upd_pc_EX + 32'd4;

    // Training-side lookup.
    logic [IDX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0] w_up_tag;
    logic                w_up_hit;
    logic [1:0]          w_up_cnt;

    assign w_up_idx = bus.upd_pc_EX[IDX_BITS+1:2];
    assign w_up_tag = bus.upd_pc_EX[31:IDX_BITS+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_cnt = r_cnt[w_up_idx];

    // Single table write port shared by the INIT clear and RUN training.
    logic                w_we;
    logic [IDX_BITS-1:0] w_widx;
    logic                w_wvalid;
    logic [TAG_BITS-1:0] w_wtag;
    logic [31:0]         w_wtarget;
    logic [1:0]          w_wcnt;

    always_comb begin
        w_we      = 1'b0;
        w_widx    = w_up_idx;
        w_wvalid  = 1'b0;
        w_wtag    = w_up_tag;
        w_wtarget = bus.upd_target_EX;
        w_wcnt    = 2'd0;
        unique case (r_state)
            StInit: begin
                w_we   = 1'b1;
                w_widx = r_init_idx;
            end
            StRun: begin
                if (bus.upd_valid_EX) begin
                    if (w_up_hit) begin
                        // Entry stays valid even when the counter bottoms out.
                        w_we     = 1'b1;
                        w_wvalid = 1'b1;
                        if (bus.upd_taken_EX) begin
                            w_wcnt = (w_up_cnt == 2'd3) ? 2'd3 : w_up_cnt + 2'd1;
                        end else begin
                            w_wtarget = r_target[w_up_idx];
                            w_wcnt    = (w_up_cnt == 2'd0) ? 2'd0 : w_up_cnt - 2'd1;
                        end
                    end else if (bus.upd_taken_EX) begin
                        w_we     = 1'b1;
                        w_wvalid = 1'b1;
                        w_wcnt   = CNT_INIT;
                    end
                end
            end
            default: ;
        endcase
    end

    // Next-state and statistics.
    always_comb begin
        w_state_next    = r_state;
        w_init_idx_next = r_init_idx;
        unique case (r_state)
            StInit: begin
                w_init_idx_next = r_init_idx + 1'b1;
                if (&r_init_idx) begin
                    w_state_next = StRun;
                end
            end
            StRun:   ;
            default: w_state_next = StInit;
        endcase

        w_stat_branches_next = r_stat_branches;
        if (bus.upd_valid_EX && !(&r_stat_branches)) begin
            w_stat_branches_next = r_stat_branches + 32'd1;
        end
        w_stat_mispredicts_next = r_stat_mispredicts;
        if (bus.mispredict_EX && !(&r_stat_mispredicts)) begin
            w_stat_mispredicts_next = r_stat_mispredicts + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= StInit;
            r_init_idx         <= '0;
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            r_state            <= w_state_next;
            r_init_idx         <= w_init_idx_next;
            r_stat_branches    <= w_stat_branches_next;
            r_stat_mispredicts <= w_stat_mispredicts_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_valid[w_widx]  <= w_wvalid;
            r_tag[w_widx]    <= w_wtag;
            r_target[w_widx] <= w_wtarget;
            r_cnt[w_widx]    <= w_wcnt;
        end
    end

    assign bus.init_busy        = (r_state == StInit);
    assign bus.stat_branches    = r_stat_branches;
    assign bus.stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_bht_btb_predictor.sv
// ----------------------------------------------------------------------------
// tb_bht_btb_predictor
// Purpose : Directed self-checking bench for bht_btb_predictor. Each step
//           drives the fetch PC and EX update, queues the expected value of
//           every output, then compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_bht_btb_predictor;
    logic clk = 1'b0;
    logic rst;

    bht_btb_predictor_if bus ();

    bht_btb_predictor #(
        .IDX_BITS (6),
        .CNT_INIT (2'b10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_br;
    logic [31:0] m_mp;

    task automatic push_exp(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.value) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic set_in(input logic [31:0] pc_if, input logic v, input logic [31:0] upc,
                          input logic tk, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
        bus.pc_IF          = pc_if;
        bus.upd_valid_EX   = v;
        bus.upd_pc_EX      = upc;
        bus.upd_taken_EX   = tk;
        bus.upd_target_EX  = tgt;
        bus.pred_taken_EX  = ptk;
        bus.pred_target_EX = ptgt;
    endtask

    task automatic idle(input logic [31:0] pc_if);
        set_in(pc_if, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Queue expectations for the current inputs, compare mid-cycle, then
    // advance the statistics model and move to just after the next edge.
    task automatic step(input string name, input logic ptk, input logic [31:0] ptgt,
                        input logic misp, input logic [31:0] redir, input logic busy);
        push_exp({name, ".pred_taken_IF"},  {31'd0, ptk});
        push_exp({name, ".pred_target_IF"}, ptgt);
        push_exp({name, ".mispredict_EX"},  {31'd0, misp});
        push_exp({name, ".redirect_pc_EX"}, redir);
        push_exp({name, ".init_busy"},      {31'd0, busy});
        push_exp({name, ".stat_branches"},  m_br);
        push_exp({name, ".stat_mispred"},   m_mp);
        @(negedge clk);
        pop_cmp({31'd0, bus.pred_taken_IF});
        pop_cmp(bus.pred_target_IF);
        pop_cmp({31'd0, bus.mispredict_EX});
        pop_cmp(bus.redirect_pc_EX);
        pop_cmp({31'd0, bus.init_busy});
        pop_cmp(bus.stat_branches);
        pop_cmp(bus.stat_mispredicts);
        if (bus.upd_valid_EX && (m_br != 32'hFFFF_FFFF)) m_br = m_br + 32'd1;
        if (misp && (m_mp != 32'hFFFF_FFFF)) m_mp = m_mp + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle(32'd0);
        m_br = 32'd0;
        m_mp = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First clear, interrupted at cycle 30; one EX update inside INIT.
        for (int i = 0; i < 30; i++) begin
            if (i == 10) begin
                set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
                step("init_upd", 1'b0, 32'd0, 1'b1, 32'h80, 1'b1);
            end else begin
                idle(32'h100 + 32'(i) * 32'd4);
                step("init_a", 1'b0, 32'd0, 1'b0, 32'd4, 1'b1);
            end
        end

        // Reset mid-init restarts the full 64-cycle clear and zeroes stats.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_br = 32'd0;
        m_mp = 32'd0;
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        step("init_drop", 1'b0, 32'd0, 1'b1, 32'h80, 1'b1);
        for (int i = 0; i < 63; i++) begin
            idle(32'h100);
            step("init_b", 1'b0, 32'd0, 1'b0, 32'd4, 1'b1);
        end

        // RUN: allocate, then walk the counter down and back up.
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        step("alloc", 1'b0, 32'd0, 1'b1, 32'h80, 1'b0);
        idle(32'h100);
        step("hit_cnt2", 1'b1, 32'h80, 1'b0, 32'd4, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        step("nt1", 1'b1, 32'h80, 1'b1, 32'h104, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'd0);
        step("nt2", 1'b0, 32'd0, 1'b0, 32'h104, 1'b0);
        idle(32'h100);
        step("cnt0", 1'b0, 32'd0, 1'b0, 32'd4, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        step("tk1", 1'b0, 32'd0, 1'b1, 32'h80, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        step("tk2", 1'b0, 32'd0, 1'b1, 32'h80, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        step("tk3", 1'b1, 32'h80, 1'b0, 32'h80, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        step("tk_sat", 1'b1, 32'h80, 1'b0, 32'h80, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        step("nt_after_sat", 1'b1, 32'h80, 1'b1, 32'h104, 1'b0);

        // Target change with same-cycle lookup of the same entry.
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        step("tgt_chg", 1'b1, 32'h80, 1'b1, 32'h90, 1'b0);
        idle(32'h100);
        step("tgt_new", 1'b1, 32'h90, 1'b0, 32'd4, 1'b0);

        // Not-taken miss on an aliasing PC writes nothing.
        set_in(32'h100, 1'b1, 32'h300, 1'b0, 32'h380, 1'b1, 32'h380);
        step("nt_300", 1'b1, 32'h90, 1'b1, 32'h304, 1'b0);
        idle(32'h300);
        step("miss_300", 1'b0, 32'd0, 1'b0, 32'd4, 1'b0);
        idle(32'h100);
        step("still_100", 1'b1, 32'h90, 1'b0, 32'd4, 1'b0);

        // Taken miss on an aliasing PC replaces the entry with CNT_INIT.
        set_in(32'h200, 1'b1, 32'h200, 1'b1, 32'h40, 1'b0, 32'd0);
        step("alias", 1'b0, 32'd0, 1'b1, 32'h40, 1'b0);
        idle(32'h100);
        step("alias_old", 1'b0, 32'd0, 1'b0, 32'd4, 1'b0);
        idle(32'h200);
        step("alias_new", 1'b1, 32'h40, 1'b0, 32'd4, 1'b0);
        idle(32'h204);
        step("other_idx", 1'b0, 32'd0, 1'b0, 32'd4, 1'b0);
        set_in(32'h200, 1'b1, 32'h200, 1'b0, 32'h40, 1'b1, 32'h40);
        step("alias_nt", 1'b1, 32'h40, 1'b1, 32'h204, 1'b0);
        idle(32'h200);
        step("alias_cnt1", 1'b0, 32'd0, 1'b0, 32'd4, 1'b0);

        // Statistics saturation.
        force dut.r_stat_branches    = 32'hFFFF_FFFE;
        force dut.r_stat_mispredicts = 32'hFFFF_FFFE;
        #1;
        release dut.r_stat_branches;
        release dut.r_stat_mispredicts;
        m_br = 32'hFFFF_FFFE;
        m_mp = 32'hFFFF_FFFE;
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        step("sat_a", 1'b0, 32'd0, 1'b1, 32'h80, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        step("sat_b", 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        set_in(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        step("sat_c", 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        idle(32'h100);
        step("sat_d", 1'b1, 32'h80, 1'b0, 32'd4, 1'b0);

        // Reset after training: no prediction during INIT, entry gone after.
        rst = 1'b1;
        idle(32'h100);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_br = 32'd0;
        m_mp = 32'd0;
        for (int i = 0; i < 64; i++) begin
            idle(32'h100);
            step("reinit", 1'b0, 32'd0, 1'b0, 32'd4, 1'b1);
        end
        idle(32'h100);
        step("post_reinit", 1'b0, 32'd0, 1'b0, 32'd4, 1'b0);

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
